multicycle_sequencer: RTL

Multi-cycle state sequencer that consumes the instruction fields (instr_type/opcode) decoded by the main control unit and issues per-cycle strobes: fetch, decode, execute, memory and write-back enables, plus PC update. It sits between the instruction register and the datapath. It handshakes with instruction and data memory and counts retired instructions.

---
 rtl/multicycle_sequencer_if.sv | 40 ++++
 rtl/multicycle_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/memory signal bundle.
// master: sequencer side; slave: datapath, IR and memory side.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       instr_type;
  logic [4:0]       opcode;
  logic             zero_flag;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_wr;
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             alu_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_wr_en;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  instr_type, opcode, zero_flag,
    input  imem_ready, dmem_ready,
    output imem_req, ir_wr, pc_wr, pc_src,
    output alu_en, dmem_req, dmem_we,
    output reg_wr_en, illegal, state,
    output retired_count
  );

  modport slave (
    output instr_type, opcode, zero_flag,
    output imem_ready, dmem_ready,
    input  imem_req, ir_wr, pc_wr, pc_src,
    input  alu_en, dmem_req, dmem_we,
    input  reg_wr_en, illegal, state,
    input  retired_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// Ports: clk, reset (async, active-high), bus (master modport).
module multicycle_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100
  } state_t;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_I = 2'b01;
  localparam logic [1:0] T_J = 2'b10;
  localparam logic [1:0] T_S = 2'b11;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       typ_q;
  logic [4:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  logic       imem_req_c;
  logic       ir_wr_c;
  logic       pc_wr_c;
  logic [1:0] pc_src_c;
  logic       alu_en_c;
  logic       dmem_req_c;
  logic       dmem_we_c;
  logic       reg_wr_c;
  logic       illegal_c;
  logic       retire_c;

  function automatic logic is_legal(
    input logic [1:0] t,
    input logic [4:0] o
  );
    logic ok;
    ok = 1'b0;
    unique case (t)
      T_R: ok = (o < 5'd4);
      T_I: ok = (o < 5'd5);
      T_J: ok = (o < 5'd2);
      T_S: ok = (o < 5'd4);
    endcase
    return ok;
  endfunction

  // Live fields classify the instruction in DECODE;
  // latched fields drive every later state.
  logic dec_legal;
  logic dec_j;
  logic dec_jal;
  logic lat_beq;
  logic lat_lw;
  logic lat_sw;
  logic lat_jal;

  assign dec_legal = is_legal(bus.instr_type, bus.opcode);
  assign dec_j     = (bus.instr_type == T_J)
                   && (bus.opcode == 5'd0);
  assign dec_jal   = (bus.instr_type == T_J)
                   && (bus.opcode == 5'd1);
  assign lat_beq   = (typ_q == T_I) && (op_q == 5'd4);
  assign lat_lw    = (typ_q == T_I) && (op_q == 5'd2);
  assign lat_sw    = (typ_q == T_I) && (op_q == 5'd3);
  assign lat_jal   = (typ_q == T_J) && (op_q == 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      typ_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        typ_q <= bus.instr_type;
        op_q  <= bus.opcode;
      end
      if (retire_c)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req_c = 1'b0;
    ir_wr_c    = 1'b0;
    pc_wr_c    = 1'b0;
    pc_src_c   = PC_INC;
    alu_en_c   = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_wr_c   = 1'b0;
    illegal_c  = 1'b0;
    retire_c   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) begin
          ir_wr_c = 1'b1;
          pc_wr_c = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!dec_legal) begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end else if (dec_j) begin
          pc_wr_c  = 1'b1;
          pc_src_c = PC_JMP;
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (dec_jal) begin
          state_d = WB;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_en_c = 1'b1;
        if (lat_beq) begin
          // Not-taken branch leaves pc_src at PC+1.
          pc_wr_c  = bus.zero_flag;
          pc_src_c = bus.zero_flag ? PC_BR : PC_INC;
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (lat_lw || lat_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = lat_sw;
        if (bus.dmem_ready) begin
          if (lat_sw) begin
            retire_c = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_wr_c = 1'b1;
        if (lat_jal) begin
          pc_wr_c  = 1'b1;
          pc_src_c = PC_JMP;
        end
        retire_c = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset state is FETCH, so strobes are masked
  // while reset is held to keep imem_req low too.
  assign bus.imem_req  = imem_req_c & ~reset;
  assign bus.ir_wr     = ir_wr_c    & ~reset;
  assign bus.pc_wr     = pc_wr_c    & ~reset;
  assign bus.pc_src    = reset ? PC_INC : pc_src_c;
  assign bus.alu_en    = alu_en_c   & ~reset;
  assign bus.dmem_req  = dmem_req_c & ~reset;
  assign bus.dmem_we   = dmem_we_c  & ~reset;
  assign bus.reg_wr_en = reg_wr_c   & ~reset;
  assign bus.illegal   = illegal_c  & ~reset;
  assign bus.state     = state_q;
  assign bus.retired_count = cnt_q;

endmodule
